game_timebase: RTL and testbench

Front-end timing stage for the sequence-memory game. It turns the single board clock into the signals the game core consumes: the free-running 10-bit `clockcount` used as the sequence seed, the slow sequence-display strobe `cout1`, the auxiliary strobe `cout2`, and debounced, active-low `KEY[1:0]`. It sits directly upstream of the game core, between the board pins and the core's `clockcount`, `cout1`, `cout2` and `KEY` inputs.

---
 rtl/game_timebase.sv | 144 ++++++++++++++
 tb/tb_game_timebase.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/game_timebase.sv
// Front-end timebase for the sequence-memory game: seed counter, two square-wave
// strobes and per-key synchronize/debounce with a one-cycle press strobe.

module game_timebase_div #(
   parameter int HALF = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic tog
);
   localparam int W = (HALF > 1) ? $clog2(HALF) : 1;

   logic [W-1:0] d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d   <= '0;
         tog <= 1'b0;
      end else if (d == W'(HALF - 1)) begin
         d   <= '0;
         tog <= ~tog;
      end else begin
         d <= d + 1'b1;
      end
   end
endmodule

module game_timebase_key #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key,
   output logic key_press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {STABLE_HI, WAIT_LO, STABLE_LO, WAIT_HI} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] c, c_nx;
   logic          key_nx, press_nx;
   logic          s1, s2;

   // Sync flops idle high so a released key never looks pressed out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= key_raw;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= STABLE_HI;
         c         <= '0;
         key       <= 1'b1;
         key_press <= 1'b0;
      end else begin
         state     <= state_nx;
         c         <= c_nx;
         key       <= key_nx;
         key_press <= press_nx;
      end
   end

   always_comb begin
      state_nx = state;
      c_nx     = c;
      key_nx   = key;
      press_nx = 1'b0;
      case (state)
         STABLE_HI: if (!s2) begin
            state_nx = WAIT_LO;
            c_nx     = '0;
         end
         WAIT_LO: begin
            if (s2) begin
               state_nx = STABLE_HI;
            end else if (c == CW'(DEBOUNCE_CYCLES - 1)) begin
               state_nx = STABLE_LO;
               key_nx   = 1'b0;
               press_nx = 1'b1;
            end else begin
               c_nx = c + 1'b1;
            end
         end
         STABLE_LO: if (s2) begin
            state_nx = WAIT_HI;
            c_nx     = '0;
         end
         WAIT_HI: begin
            if (!s2) begin
               state_nx = STABLE_LO;
            end else if (c == CW'(DEBOUNCE_CYCLES - 1)) begin
               state_nx = STABLE_HI;
               key_nx   = 1'b1;
            end else begin
               c_nx = c + 1'b1;
            end
         end
         default: state_nx = STABLE_HI;
      endcase
   end
endmodule

module game_timebase #(
   parameter int COUT1_HALF      = 25_000_000,
   parameter int COUT2_HALF      = 6_250_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] KEY_raw,
   output logic [1:0] KEY,
   output logic [1:0] key_press,
   output logic [9:0] clockcount,
   output logic       cout1,
   output logic       cout2
);
   localparam int NUM_KEYS = 2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) clockcount <= '0;
      else       clockcount <= clockcount + 1'b1;
   end

   game_timebase_div #(.HALF(COUT1_HALF)) u_div1 (.clk(clk), .reset(reset), .tog(cout1));
   game_timebase_div #(.HALF(COUT2_HALF)) u_div2 (.clk(clk), .reset(reset), .tog(cout2));

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      game_timebase_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
         .clk      (clk),
         .reset    (reset),
         .key_raw  (KEY_raw[i]),
         .key      (KEY[i]),
         .key_press(key_press[i])
      );
   end
endmodule

// File: tb/tb_game_timebase.sv
// Bench for game_timebase: directed timeline with literal expectations plus a
// random key phase, all checked every cycle against a run-length key model.

module tb_game_timebase;
   localparam int H1 = 4;
   localparam int H2 = 3;
   localparam int DB = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] KEY_raw = 2'b11;
   logic [1:0] KEY, key_press;
   logic [9:0] clockcount;
   logic       cout1, cout2;

   int checks = 0;
   int failures = 0;
   int e = 0;

   game_timebase #(.COUT1_HALF(H1), .COUT2_HALF(H2), .DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .KEY_raw(KEY_raw), .KEY(KEY),
      .key_press(key_press), .clockcount(clockcount), .cout1(cout1), .cout2(cout2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
      end
   endtask

   // Model: n edges since reset; a key flips once the delayed raw level has
   // disagreed with the debounced level for DB+1 consecutive edges.
   int         n;
   int         run [2];
   logic [1:0] m_key, m_press, dly1, dly2;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         n = 0; run[0] = 0; run[1] = 0;
         m_key = 2'b11; m_press = 2'b00; dly1 = 2'b11; dly2 = 2'b11;
      end else begin
         n++;
         m_press = 2'b00;
         for (int i = 0; i < 2; i++) begin
            if (dly2[i] != m_key[i]) begin
               run[i]++;
               if (run[i] == DB + 1) begin
                  m_key[i] = dly2[i];
                  m_press[i] = !dly2[i];
                  run[i] = 0;
               end
            end else begin
               run[i] = 0;
            end
         end
         dly2 = dly1;
         dly1 = KEY_raw;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("model_clockcount", 32'(clockcount), 32'(n % 1024));
         chk("model_cout1", 32'(cout1), 32'((n / H1) % 2));
         chk("model_cout2", 32'(cout2), 32'((n / H2) % 2));
         chk("model_KEY", 32'(KEY), 32'(m_key));
         chk("model_key_press", 32'(key_press), 32'(m_press));
      end
   end

   task automatic to_edge(input int k);
      while (e < k) begin
         @(posedge clk);
         e++;
      end
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_clockcount"}, 32'(clockcount), 0);
      chk({tag, "_cout1"}, 32'(cout1), 0);
      chk({tag, "_cout2"}, 32'(cout2), 0);
      chk({tag, "_KEY"}, 32'(KEY), 32'h3);
      chk({tag, "_key_press"}, 32'(key_press), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk_reset_vals("reset");
      @(negedge clk);
      #2 reset = 1'b0;
      e = 0;
   endtask

   initial begin
      do_reset();
      to_edge(3);  chk("cout1_e3", 32'(cout1), 0); chk("cout2_e3", 32'(cout2), 1);
      to_edge(4);  chk("cout1_e4", 32'(cout1), 1);
      to_edge(11); chk("cout1_e11", 32'(cout1), 0);
      to_edge(12); chk("cout1_e12", 32'(cout1), 1);
      // clean press/release on key 0
      to_edge(19); KEY_raw[0] = 1'b0;
      to_edge(26); chk("press_e26_KEY", 32'(KEY), 32'h3);
      to_edge(27); chk("press_e27_KEY", 32'(KEY), 32'h2); chk("press_e27_kp", 32'(key_press), 32'h1);
      to_edge(28); chk("press_e28_kp", 32'(key_press), 0);
      to_edge(39); KEY_raw[0] = 1'b1;
      to_edge(46); chk("rel_e46_KEY", 32'(KEY), 32'h2);
      to_edge(47); chk("rel_e47_KEY", 32'(KEY), 32'h3); chk("rel_e47_kp", 32'(key_press), 0);
      // bounce on key 1: low 3, high 2, then held low from before edge 55
      to_edge(49); KEY_raw[1] = 1'b0;
      to_edge(52); KEY_raw[1] = 1'b1;
      to_edge(54); KEY_raw[1] = 1'b0;
      to_edge(61); chk("bounce_e61_KEY", 32'(KEY), 32'h3); chk("bounce_e61_kp", 32'(key_press), 0);
      to_edge(62); chk("bounce_e62_KEY", 32'(KEY), 32'h1); chk("bounce_e62_kp", 32'(key_press), 32'h2);
      to_edge(70); KEY_raw = 2'b11;
      // simultaneous press
      to_edge(99); KEY_raw = 2'b00;
      to_edge(107); chk("simul_e107_kp", 32'(key_press), 32'h3); chk("simul_e107_KEY", 32'(KEY), 0);
      to_edge(108); chk("simul_e108_kp", 32'(key_press), 0);
      to_edge(120); KEY_raw = 2'b11;
      to_edge(1023); chk("cc_e1023", 32'(clockcount), 1023);
      to_edge(1024); chk("cc_e1024", 32'(clockcount), 0);
      to_edge(1030);
      // random key activity, checked by the model every cycle
      for (int it = 0; it < 300; it++) begin
         KEY_raw = 2'($urandom_range(0, 3));
         to_edge(e + int'($urandom_range(1, 12)));
      end
      // asynchronous reset mid-operation with key 0 held
      KEY_raw = 2'b11;
      do_reset();
      KEY_raw = 2'b10;
      to_edge(300);
      chk("mid_pre_KEY", 32'(KEY), 32'h2);
      chk("mid_pre_cout1", 32'(cout1), 1);
      chk("mid_pre_cc", 32'(clockcount), 300);
      #2 reset = 1'b1;
      #1 chk_reset_vals("mid_async");
      @(negedge clk);
      #2 reset = 1'b0;
      e = 0;
      // held through reset: key seen low before edge 1, accepted at edge 1+2+DB
      to_edge(7); chk("mid_e7_KEY", 32'(KEY), 32'h3);
      to_edge(8); chk("mid_e8_KEY", 32'(KEY), 32'h2); chk("mid_e8_kp", 32'(key_press), 32'h1);
      to_edge(9); chk("mid_e9_kp", 32'(key_press), 0);
      to_edge(20);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
